// File: rtl/regfile_mp.sv
// Multi-read-port GPR file with load-size write extension and a per-register busy scoreboard.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write to the read ports.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     rd_valid,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [2:0]               wr_mode,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic [NUM_REGS-1:0]      busy_next;
  logic                     wr_ok;
  logic [DATA_W-1:0]        wr_val;
  logic [NUM_RD*DATA_W-1:0] rd_data_next;
  logic [NUM_RD-1:0]        rd_busy_next;

  function automatic logic [DATA_W-1:0] ext(input logic [DATA_W-1:0] d, input logic [2:0] m);
    case (m)
      3'd0:    ext = {{(DATA_W-8){1'b0}}, d[7:0]};
      3'd1:    ext = {{(DATA_W-16){1'b0}}, d[15:0]};
      3'd2:    ext = {{(DATA_W-16){d[15]}}, d[15:0]};
      3'd3:    ext = {{(DATA_W-32){1'b0}}, d[31:0]};
      3'd4:    ext = {{(DATA_W-32){d[31]}}, d[31:0]};
      default: ext = d;
    endcase
  endfunction

  // Modes 6 and 7 are reserved: they neither write nor release the scoreboard.
  assign wr_ok  = wr_en && (wr_mode <= 3'd5);
  assign wr_val = ext(wr_data, wr_mode);

  // Reservation is applied after the writeback clear so a same-cycle reserve wins.
  always_comb begin
    busy_next = busy_vec;
    if (wr_ok)  busy_next[wr_addr]  = 1'b0;
    if (rsv_en) busy_next[rsv_addr] = 1'b1;
  end

  always_comb begin
    rd_data_next = '0;
    rd_busy_next = '0;
    for (int i = 0; i < NUM_RD; i++) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (wr_addr == rd_addr[i*AW +: AW]))
        rd_data_next[i*DATA_W +: DATA_W] = wr_val;
      else
        rd_data_next[i*DATA_W +: DATA_W] = regs[rd_addr[i*AW +: AW]];
      rd_busy_next[i] = busy_next[rd_addr[i*AW +: AW]];
`else
      rd_data_next[i*DATA_W +: DATA_W] = regs[rd_addr[i*AW +: AW]];
      rd_busy_next[i] = busy_vec[rd_addr[i*AW +: AW]];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      busy_vec <= '0;
      rd_data  <= '0;
      rd_busy  <= '0;
      rd_valid <= 1'b0;
    end else begin
      busy_vec <= busy_next;
      if (wr_ok) regs[wr_addr] <= wr_val;
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_data_next;
        rd_busy <= rd_busy_next;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (3 read ports); read expectations go through a scoreboard queue.
module tb_regfile_mp;

  localparam int DW = 64;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NP = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_en = 1'b0;
  logic [NP*AW-1:0]  rd_addr = '0;
  logic [NP*DW-1:0]  rd_data;
  logic [NP-1:0]     rd_busy;
  logic              rd_valid;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [2:0]        wr_mode = '0;
  logic [DW-1:0]     wr_data = '0;
  logic              rsv_en = 1'b0;
  logic [AW-1:0]     rsv_addr = '0;
  logic [NR-1:0]     busy_vec;

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .AW(AW), .NUM_RD(NP)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_mode(wr_mode), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP*DW-1:0] data;
    logic [NP-1:0]    busy;
  } exp_t;

  exp_t             sb_q[$];
  logic [DW-1:0]    m_regs [NR];
  logic [NR-1:0]    m_busy = '0;
  logic [NP*DW-1:0] last_data = '0;
  logic [NP-1:0]    last_busy = '0;
  int               n_vec = 0;
  int               n_err = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic logic [DW-1:0] m_ext(input logic [DW-1:0] d, input logic [2:0] m);
    case (m)
      3'd0:    return {56'd0, d[7:0]};
      3'd1:    return {48'd0, d[15:0]};
      3'd2:    return {{48{d[15]}}, d[15:0]};
      3'd3:    return {32'd0, d[31:0]};
      3'd4:    return {{32{d[31]}}, d[31:0]};
      default: return d;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [NP*DW-1:0] obs, input logic [NP*DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, push the read expectation, advance, then pop and compare.
  task automatic step(input bit rst, input bit rd, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input bit wr, input logic [AW-1:0] wa,
                      input logic [2:0] wm, input logic [DW-1:0] wd, input bit rsv,
                      input logic [AW-1:0] ra);
    logic [AW-1:0] addrs [NP];
    logic [NR-1:0] nb;
    logic          wok;
    logic [DW-1:0] wv;
    exp_t          e;
    rst_n = !rst; rd_en = rd; rd_addr = {a2, a1, a0};
    wr_en = wr; wr_addr = wa; wr_mode = wm; wr_data = wd; rsv_en = rsv; rsv_addr = ra;
    addrs[0] = a0; addrs[1] = a1; addrs[2] = a2;
    wok = wr && (wm <= 3'd5);
    wv  = m_ext(wd, wm);
    nb  = m_busy;
    if (wok) nb[wa] = 1'b0;
    if (rsv) nb[ra] = 1'b1;
    if (rd && !rst) begin
      for (int i = 0; i < NP; i++) begin
        if (BYP && wok && (wa == addrs[i])) e.data[i*DW +: DW] = wv;
        else                                e.data[i*DW +: DW] = m_regs[addrs[i]];
        e.busy[i] = BYP ? nb[addrs[i]] : m_busy[addrs[i]];
      end
      sb_q.push_back(e);
    end
    if (rst) begin
      for (int r = 0; r < NR; r++) m_regs[r] = '0;
      m_busy = '0;
    end else begin
      if (wok) m_regs[wa] = wv;
      m_busy = nb;
    end
    @(posedge clk);
    #1;
    chk("rd_valid", {191'd0, rd_valid}, {191'd0, rd && !rst});
    if (rst) begin
      last_data = '0; last_busy = '0;
      chk("rst_data", rd_data, '0);
      chk("rst_busy", {189'd0, rd_busy}, '0);
    end else if (rd) begin
      if (sb_q.size() == 0) begin
        n_vec++; n_err++;
        $error("FAIL sb_empty: observed 0 entries expected 1");
      end else begin
        e = sb_q.pop_front();
        last_data = e.data; last_busy = e.busy;
        chk("rd_data", rd_data, e.data);
        chk("rd_busy", {189'd0, rd_busy}, {189'd0, e.busy});
      end
    end else begin
      chk("hold_data", rd_data, last_data);
      chk("hold_busy", {189'd0, rd_busy}, {189'd0, last_busy});
    end
    chk("busy_vec", {160'd0, busy_vec}, {160'd0, m_busy});
  endtask

  task automatic rd3(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    step(0, 1, a0, a1, a2, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic wr1(input logic [AW-1:0] wa, input logic [2:0] wm, input logic [DW-1:0] wd);
    step(0, 0, 0, 0, 0, 1, wa, wm, wd, 0, 0);
  endtask

  task automatic rsv1(input logic [AW-1:0] ra);
    step(0, 0, 0, 0, 0, 0, 0, 0, '0, 1, ra);
  endtask

  logic [DW-1:0] ext_exp [6];
  logic [DW-1:0] pat;

  initial begin
    ext_exp[0] = 64'hF0;
    ext_exp[1] = 64'hF0F0;
    ext_exp[2] = 64'hFFFF_FFFF_FFFF_F0F0;
    ext_exp[3] = 64'h8000_F0F0;
    ext_exp[4] = 64'hFFFF_FFFF_8000_F0F0;
    ext_exp[5] = 64'hFFFF_FFFF_8000_F0F0;
    pat = 64'hFFFF_FFFF_8000_F0F0;
    for (int r = 0; r < NR; r++) m_regs[r] = '0;

    step(1, 1, 3, 7, 0, 0, 0, 0, '0, 0, 0);
    chk("reset_busy_vec", {160'd0, busy_vec}, '0);
    rd3(3, 7, 0);
    chk("reset_read", rd_data, '0);

    for (int m = 0; m < 6; m++) begin
      wr1(4, m[2:0], pat);
      rd3(4, 4, 4);
      chk($sformatf("ext_mode%0d", m), {128'd0, rd_data[63:0]}, {128'd0, ext_exp[m]});
      chk($sformatf("ext_mode%0d_p2", m), {128'd0, rd_data[191:128]}, {128'd0, ext_exp[m]});
    end
    wr1(4, 3'd6, 64'h1);
    rd3(4, 0, 0);
    chk("mode6_nowrite", {128'd0, rd_data[63:0]}, {128'd0, pat});
    rsv1(4);
    wr1(4, 3'd7, 64'h2);
    chk("mode7_keeps_busy", {191'd0, busy_vec[4]}, 192'd1);

    rsv1(9);
    rd3(9, 0, 0);
    chk("sb_busy_set", {191'd0, rd_busy[0]}, 192'd1);
    wr1(9, 3'd5, 64'd5);
    rd3(9, 0, 0);
    chk("sb_data", {128'd0, rd_data[63:0]}, 192'd5);
    chk("sb_busy_clr", {191'd0, rd_busy[0]}, 192'd0);
    step(0, 0, 0, 0, 0, 1, 9, 3'd5, 64'd6, 1, 9);
    chk("sb_rsv_wins", {191'd0, busy_vec[9]}, 192'd1);
    rsv1(9);
    chk("sb_rsv_again", {191'd0, busy_vec[9]}, 192'd1);
    wr1(9, 3'd5, 64'd7);
    wr1(10, 3'd5, 64'd8);
    chk("sb_write_idle", {190'd0, busy_vec[10:9]}, 192'd0);

    wr1(2, 3'd5, 64'hAAAA);
    rsv1(2);
    step(0, 1, 2, 2, 0, 1, 2, 3'd5, 64'h1234, 0, 0);
    chk("bypass_data", {128'd0, rd_data[63:0]}, BYP ? 192'h1234 : 192'hAAAA);
    chk("bypass_busy", {191'd0, rd_busy[0]}, BYP ? 192'd0 : 192'd1);
    rd3(2, 0, 0);
    chk("after_write", {128'd0, rd_data[63:0]}, 192'h1234);

    wr1(1, 3'd5, 64'hDEAD_BEEF_0000_0011);
    rd3(1, 1, 0);
    chk("mp_port0", {128'd0, rd_data[63:0]}, {128'd0, 64'hDEAD_BEEF_0000_0011});
    chk("mp_port1", {128'd0, rd_data[127:64]}, {128'd0, 64'hDEAD_BEEF_0000_0011});
    chk("mp_port2", {128'd0, rd_data[191:128]}, 192'd0);
    step(0, 0, 5, 6, 7, 0, 0, 0, '0, 0, 0);

    rsv1(5);
    step(1, 1, 5, 5, 5, 1, 5, 3'd5, 64'h55, 1, 5);
    rd3(5, 1, 9);
    chk("rst_mid_data", rd_data, '0);
    chk("rst_mid_busy", {160'd0, busy_vec}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
